// File: rtl/dqsw_lane_delay_trainer_if.sv
// Bundle between the write-levelling trainer, the training sequencer and the
// per-lane DQSW IODs: sequencer handshake, IOD delay-line controls and results.
interface dqsw_lane_delay_trainer_if #(
   parameter int NUM_LANES = 2,
   parameter int TAP_BITS  = 8
);
   logic                          TRAIN_START;
   logic [NUM_LANES-1:0]          RX_DATA_IN;
   logic [NUM_LANES-1:0]          DELAY_LINE_OUT_OF_RANGE;
   logic [NUM_LANES-1:0]          DELAY_LINE_LOAD;
   logic [NUM_LANES-1:0]          DELAY_LINE_MOVE;
   logic [NUM_LANES-1:0]          DELAY_LINE_DIRECTION;
   logic                          TRAIN_BUSY;
   logic                          TRAIN_DONE;
   logic [NUM_LANES-1:0]          TRAIN_FAIL;
   logic [NUM_LANES*TAP_BITS-1:0] LANE_TAP;

   // Sequencer/IOD side: drives the request and lane feedback.
   modport master (
      output TRAIN_START, RX_DATA_IN, DELAY_LINE_OUT_OF_RANGE,
      input  DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
      input  TRAIN_BUSY, TRAIN_DONE, TRAIN_FAIL, LANE_TAP
   );

   // Trainer side.
   modport slave (
      input  TRAIN_START, RX_DATA_IN, DELAY_LINE_OUT_OF_RANGE,
      output DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
      output TRAIN_BUSY, TRAIN_DONE, TRAIN_FAIL, LANE_TAP
   );
endinterface

// File: rtl/dqsw_lane_delay_trainer.sv
// DQSW write-levelling trainer: sweeps each lane's IOD delay line from tap 0
// and records the first tap where the filtered RX sample goes stable 0 -> 1.
module dqsw_lane_delay_trainer #(
   parameter int NUM_LANES     = 2,
   parameter int TAP_BITS      = 8,
   parameter int MAX_TAP       = 127,
   parameter int SETTLE_CYCLES = 4,
   parameter int SAMPLE_COUNT  = 4
) (
   input logic                      FAB_CLK,
   input logic                      RESET,
   dqsw_lane_delay_trainer_if.slave bus
);

   localparam int LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_COUNT) ? SETTLE_CYCLES : SAMPLE_COUNT;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_SAMPLE,
      S_DECIDE,
      S_MOVE,
      S_DONE
   } state_e;

   state_e                        state_q, state_d;
   logic [LANE_W-1:0]             lane_q, lane_d;
   logic [TAP_BITS-1:0]           tap_q, tap_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic                          acc_q, acc_d;
   logic                          seen_zero_q, seen_zero_d;
   logic                          done_q, done_d;
   logic [NUM_LANES-1:0]          fail_q, fail_d;
   logic [NUM_LANES*TAP_BITS-1:0] lane_tap_q, lane_tap_d;

   logic                          rx_lane, oor_lane;
   logic                          settle_last, sample_last;
   logic                          edge_found, lane_fail, lane_end, last_lane;
   logic [NUM_LANES-1:0]          load_o, move_o, dir_o;
   logic                          busy_o;

   assign rx_lane     = bus.RX_DATA_IN[lane_q];
   assign oor_lane    = bus.DELAY_LINE_OUT_OF_RANGE[lane_q];
   assign settle_last = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
   assign sample_last = (cnt_q == CNT_W'(SAMPLE_COUNT - 1));
   assign last_lane   = (lane_q == LANE_W'(NUM_LANES - 1));

   // acc_q is the AND of the finished window; an edge needs a 0-window earlier on this lane.
   assign edge_found  = acc_q & seen_zero_q;
   assign lane_fail   = ~edge_found & (oor_lane | (tap_q == TAP_BITS'(MAX_TAP)));
   assign lane_end    = edge_found | lane_fail;

   always_ff @(posedge FAB_CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (bus.TRAIN_START) state_d = S_LOAD;
         S_LOAD:   state_d = S_SETTLE;
         S_SETTLE: if (settle_last) state_d = S_SAMPLE;
         S_SAMPLE: if (sample_last) state_d = S_DECIDE;
         S_DECIDE: begin
            if (!lane_end) begin
               state_d = S_MOVE;
            end else if (last_lane) begin
               state_d = S_DONE;
            end else begin
               state_d = S_LOAD;
            end
         end
         S_MOVE:   state_d = S_SETTLE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      lane_d      = lane_q;
      tap_d       = tap_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      seen_zero_d = seen_zero_q;
      done_d      = done_q;
      fail_d      = fail_q;
      lane_tap_d  = lane_tap_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.TRAIN_START) begin
               lane_d     = '0;
               done_d     = 1'b0;
               fail_d     = '0;
               lane_tap_d = '0;
            end
         end
         S_LOAD: begin
            tap_d       = '0;
            seen_zero_d = 1'b0;
            cnt_d       = '0;
         end
         S_SETTLE: begin
            cnt_d = settle_last ? '0 : cnt_q + CNT_W'(1);
         end
         S_SAMPLE: begin
            // First sample of the window seeds the accumulator.
            acc_d = (cnt_q == '0) ? rx_lane : (acc_q & rx_lane);
            cnt_d = sample_last ? '0 : cnt_q + CNT_W'(1);
         end
         S_DECIDE: begin
            if (!acc_q) seen_zero_d = 1'b1;
            if (edge_found) begin
               lane_tap_d[lane_q*TAP_BITS +: TAP_BITS] = tap_q;
            end else if (lane_fail) begin
               fail_d[lane_q]                          = 1'b1;
               lane_tap_d[lane_q*TAP_BITS +: TAP_BITS] = '0;
            end
            if (lane_end) begin
               if (last_lane) begin
                  done_d = 1'b1;
               end else begin
                  lane_d = lane_q + LANE_W'(1);
               end
            end
         end
         S_MOVE: begin
            tap_d = tap_q + TAP_BITS'(1);
            cnt_d = '0;
         end
         S_DONE: begin
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge FAB_CLK) begin
      if (RESET) begin
         lane_q      <= '0;
         tap_q       <= '0;
         cnt_q       <= '0;
         acc_q       <= 1'b0;
         seen_zero_q <= 1'b0;
         done_q      <= 1'b0;
         fail_q      <= '0;
         lane_tap_q  <= '0;
      end else begin
         lane_q      <= lane_d;
         tap_q       <= tap_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         seen_zero_q <= seen_zero_d;
         done_q      <= done_d;
         fail_q      <= fail_d;
         lane_tap_q  <= lane_tap_d;
      end
   end

   // Only the active lane's bits are ever driven.
   always_comb begin
      load_o = '0;
      move_o = '0;
      dir_o  = '0;
      busy_o = 1'b0;
      unique case (state_q)
         S_LOAD, S_SETTLE, S_SAMPLE, S_DECIDE, S_MOVE: begin
            busy_o         = 1'b1;
            dir_o[lane_q]  = 1'b1;
            load_o[lane_q] = (state_q == S_LOAD);
            move_o[lane_q] = (state_q == S_MOVE);
         end
         default: begin
         end
      endcase
   end

   assign bus.DELAY_LINE_LOAD      = load_o;
   assign bus.DELAY_LINE_MOVE      = move_o;
   assign bus.DELAY_LINE_DIRECTION = dir_o;
   assign bus.TRAIN_BUSY           = busy_o;
   assign bus.TRAIN_DONE           = done_q;
   assign bus.TRAIN_FAIL           = fail_q;
   assign bus.LANE_TAP             = lane_tap_q;

endmodule

// File: tb/tb_dqsw_lane_delay_trainer.sv
// Randomised bench: IOD delay-line environment plus a per-cycle expected-output
// trace derived from the sweep rules, compared every negative edge.
module tb_dqsw_lane_delay_trainer;

   localparam int NL  = 2;
   localparam int TB  = 8;
   localparam int MT  = 127;
   localparam int SC  = 4;
   localparam int SN  = 4;
   localparam int PER = 1 + SC + SN + 1;

   typedef struct packed {
      logic [NL-1:0]    load;
      logic [NL-1:0]    move;
      logic [NL-1:0]    dir;
      logic             busy;
      logic             done;
      logic [NL-1:0]    fail;
      logic [NL*TB-1:0] tap;
   } obs_t;

   logic clk;
   logic rst;

   dqsw_lane_delay_trainer_if #(.NUM_LANES(NL), .TAP_BITS(TB)) bus ();

   dqsw_lane_delay_trainer #(
      .NUM_LANES    (NL),
      .TAP_BITS     (TB),
      .MAX_TAP      (MT),
      .SETTLE_CYCLES(SC),
      .SAMPLE_COUNT (SN)
   ) dut (
      .FAB_CLK(clk),
      .RESET  (rst),
      .bus    (bus)
   );

   int   total = 0;
   int   bad   = 0;
   bit   chk_en = 0;
   obs_t q[$];
   obs_t exp_idle;

   // Lane response: pat[l][tap] is the steady RX level; one optional glitch
   // forces RX low at tap gt, gk cycles after that tap's LOAD/MOVE pulse.
   bit pat [NL][MT+1];
   int gt [NL];
   int gk [NL];
   int oor_t [NL];

   int env_tap [NL];
   int env_k [NL];
   int moves_seen [NL];
   int load_cyc [NL];
   int cyc = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic obs_t dut_obs();
      obs_t o;
      o.load = bus.DELAY_LINE_LOAD;
      o.move = bus.DELAY_LINE_MOVE;
      o.dir  = bus.DELAY_LINE_DIRECTION;
      o.busy = bus.TRAIN_BUSY;
      o.done = bus.TRAIN_DONE;
      o.fail = bus.TRAIN_FAIL;
      o.tap  = bus.LANE_TAP;
      return o;
   endfunction

   task automatic chk(input string name, input longint got, input longint expv);
      total++;
      if (got != expv) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", name, got, expv);
      end
   endtask

   // Environment: delay line follows LOAD/MOVE, RX/OOR follow the current tap.
   initial begin
      logic [NL-1:0] rxv, oorv;
      for (int l = 0; l < NL; l++) begin
         env_tap[l] = 0;
         env_k[l]   = 100;
      end
      bus.RX_DATA_IN              = '0;
      bus.DELAY_LINE_OUT_OF_RANGE = '0;
      forever begin
         @(negedge clk);
         cyc++;
         for (int l = 0; l < NL; l++) begin
            int t;
            if (bus.DELAY_LINE_LOAD[l] === 1'b1) begin
               env_tap[l]  = 0;
               env_k[l]    = 0;
               load_cyc[l] = cyc;
            end else if (bus.DELAY_LINE_MOVE[l] === 1'b1) begin
               if (bus.DELAY_LINE_DIRECTION[l] === 1'b1) env_tap[l]++;
               env_k[l] = 0;
               moves_seen[l]++;
            end else if (env_k[l] < 100) begin
               env_k[l]++;
            end
            t = (env_tap[l] > MT) ? MT : env_tap[l];
            rxv[l]  = pat[l][t] && !(gt[l] == env_tap[l] && gk[l] == env_k[l]);
            oorv[l] = (env_tap[l] >= oor_t[l]);
         end
         bus.RX_DATA_IN              = rxv;
         bus.DELAY_LINE_OUT_OF_RANGE = oorv;
      end
   end

   // Compare process: every cycle against the expected trace (or the idle hold value).
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            obs_t e, a;
            e = (q.size() != 0) ? q.pop_front() : exp_idle;
            a = dut_obs();
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL outputs t=%0t got load=%b move=%b dir=%b busy=%b done=%b fail=%b tap=%h exp load=%b move=%b dir=%b busy=%b done=%b fail=%b tap=%h",
                        $time, a.load, a.move, a.dir, a.busy, a.done, a.fail, a.tap,
                        e.load, e.move, e.dir, e.busy, e.done, e.fail, e.tap);
            end
         end
      end
   end

   // Window result per tap, then first 0 -> 1 transition, else fail on OOR/MAX_TAP.
   function automatic void model_lane(input int l, output int last, output bit f, output int tv);
      bit seen = 0;
      last = MT; f = 1; tv = 0;
      for (int t = 0; t <= MT; t++) begin
         bit r;
         r = pat[l][t] && !(gt[l] == t && gk[l] >= 1 + SC && gk[l] <= SC + SN);
         if (!r) begin
            seen = 1;
         end else if (seen) begin
            last = t; f = 0; tv = t;
            return;
         end
         if (oor_t[l] <= t || t == MT) begin
            last = t; f = 1; tv = 0;
            return;
         end
      end
   endfunction

   // High for taps [0,h) and from e upward, low in between.
   task automatic set_lane(input int l, input int h, input int e);
      for (int t = 0; t <= MT; t++) pat[l][t] = (t < h) || (t >= e);
      gt[l]    = -1;
      gk[l]    = -1;
      oor_t[l] = 1000;
   endtask

   task automatic run_trial(input int busy_start, input int rst_at);
      obs_t e;
      int   n, last, tv;
      bit   f;
      @(posedge clk); #2;
      for (int l = 0; l < NL; l++) begin
         moves_seen[l] = 0;
         load_cyc[l]   = -1;
      end
      q.push_back(exp_idle);
      e = '0;
      for (int l = 0; l < NL; l++) begin
         model_lane(l, last, f, tv);
         for (int t = 0; t <= last; t++) begin
            for (int c = 0; c < PER; c++) begin
               e.load = '0;
               e.move = '0;
               if (c == 0 && t == 0) e.load[l] = 1'b1;
               if (c == 0 && t > 0)  e.move[l] = 1'b1;
               e.dir    = '0;
               e.dir[l] = 1'b1;
               e.busy   = 1'b1;
               e.done   = 1'b0;
               q.push_back(e);
            end
         end
         e.fail[l]         = f;
         e.tap[l*TB +: TB] = TB'(tv);
      end
      e.load = '0;
      e.move = '0;
      e.dir  = '0;
      e.busy = 1'b0;
      e.done = 1'b1;
      q.push_back(e);
      exp_idle = e;
      bus.TRAIN_START = 1'b1;
      n = 0;
      while (1) begin
         @(posedge clk); #2;
         n++;
         bus.TRAIN_START = (n == busy_start);
         rst = (n == rst_at);
         if (n == rst_at) begin
            obs_t h;
            h = q[0];
            q.delete();
            q.push_back(h);
            exp_idle = '0;
         end
         if (q.size() == 0 && n > rst_at) break;
         if (n > 4000) begin
            total++;
            bad++;
            $display("FAIL trial_timeout got=%0d exp=%0d", q.size(), 0);
            q.delete();
            break;
         end
      end
      repeat (2) @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b1;
      bus.TRAIN_START = 1'b0;
      for (int l = 0; l < NL; l++) set_lane(l, 0, 1000);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      exp_idle = '0;
      chk_en = 1;
      chk("reset_outputs", longint'(dut_obs()), 0);

      // Edges at 3 and 10.
      set_lane(0, 0, 3);
      set_lane(1, 0, 10);
      run_trial(0, 0);
      chk("t1_lane_tap", bus.LANE_TAP, 16'h0A03);
      chk("t1_model_tap", exp_idle.tap, 16'h0A03);
      chk("t1_fail", bus.TRAIN_FAIL, 0);
      chk("t1_done", bus.TRAIN_DONE, 1);
      chk("t1_moves0", moves_seen[0], 3);
      chk("t1_lane0_cycles", load_cyc[1] - load_cyc[0], 40);

      // Initial high region skipped.
      set_lane(0, 5, 9);
      set_lane(1, 0, 2);
      run_trial(0, 0);
      chk("t2_tap0", bus.LANE_TAP[7:0], 9);
      chk("t2_fail0", bus.TRAIN_FAIL[0], 0);

      // Lane1 stuck low.
      set_lane(0, 0, 5);
      set_lane(1, 0, 1000);
      run_trial(0, 0);
      chk("t3_moves1", moves_seen[1], 127);
      chk("t3_fail", bus.TRAIN_FAIL, 2);
      chk("t3_tap1", bus.LANE_TAP[15:8], 0);
      chk("t3_done", bus.TRAIN_DONE, 1);

      // Out-of-range at tap 20 on lane0.
      set_lane(0, 0, 1000);
      oor_t[0] = 20;
      set_lane(1, 0, 4);
      run_trial(0, 0);
      chk("t4_fail0", bus.TRAIN_FAIL[0], 1);
      chk("t4_lane1_start", load_cyc[1] - load_cyc[0], 210);
      chk("t4_moves0", moves_seen[0], 20);

      // Window 1,1,0,1 at tap 3.
      set_lane(0, 0, 3);
      gt[0] = 3;
      gk[0] = 1 + SC + 2;
      set_lane(1, 0, 1);
      run_trial(0, 0);
      chk("t5_tap0", bus.LANE_TAP[7:0], 4);

      // Ignored START while busy, then reset mid-SETTLE on lane1.
      set_lane(0, 0, 2);
      set_lane(1, 0, 5);
      run_trial(5, 1 + 3*PER + 2);
      chk("t6_busy", bus.TRAIN_BUSY, 0);
      chk("t6_done", bus.TRAIN_DONE, 0);
      chk("t6_tap", bus.LANE_TAP, 0);
      chk("t6_moves1", moves_seen[1], 0);

      // Retrain after reset starts again from lane0 tap 0.
      set_lane(0, 0, 6);
      set_lane(1, 2, 7);
      run_trial(0, 0);
      chk("t7_tap", bus.LANE_TAP, 16'h0706);
      chk("t7_moves0", moves_seen[0], 6);

      for (int i = 0; i < 10; i++) begin
         for (int l = 0; l < NL; l++) begin
            int h, sel;
            h   = int'($urandom_range(0, 4));
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       set_lane(l, h, h + 1 + int'($urandom_range(0, 25)));
            else if (sel == 7) set_lane(l, 0, 1000);
            else if (sel == 8) set_lane(l, 1000, 1000);
            else begin
               set_lane(l, h, h + 1 + int'($urandom_range(0, 40)));
               oor_t[l] = int'($urandom_range(0, 30));
            end
            if ($urandom_range(0, 1) == 1) begin
               gt[l] = int'($urandom_range(0, 30));
               gk[l] = int'($urandom_range(0, PER - 1));
            end
         end
         run_trial(int'($urandom_range(2, 20)), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dqsw_lane_delay_trainer.md
Name: dqsw_lane_delay_trainer

Overview:
Parametrised write-levelling trainer for the DDR4 DQSW training lanes. It sequentially sweeps the IOD dynamic delay line of each of NUM_LANES lanes from tap 0 upward and samples the lane's fabric-side RX data bit at every tap. It records the first tap where the sample goes from stable-0 to stable-1. The block sits between the DDRPHY training sequencer and the per-lane DQSW training IODs: it drives their DELAY_LINE_LOAD/MOVE/DIRECTION pins and consumes their RX data and out-of-range flags.

Parameters:
NUM_LANES, 2, number of DQSW training lanes, trained one at a time starting with lane 0 (>=1)
TAP_BITS, 8, width of each recorded tap value
MAX_TAP, 127, highest tap tried before a lane is declared failed (< 2**TAP_BITS)
SETTLE_CYCLES, 4, FAB_CLK cycles waited after every LOAD/MOVE before sampling (>=1)
SAMPLE_COUNT, 4, consecutive FAB_CLK samples taken per tap (>=1)

Ports:
FAB_CLK  input  1  single clock; all logic rising-edge
RESET  input  1  synchronous, active-high reset
TRAIN_START  input  1  one-cycle request; honoured only in IDLE
RX_DATA_IN  input  NUM_LANES  per-lane sampled DQS-vs-CK bit, FAB_CLK-synchronous
DELAY_LINE_OUT_OF_RANGE  input  NUM_LANES  per-lane IOD out-of-range flag
DELAY_LINE_LOAD  output  NUM_LANES  one-cycle load pulse; the delay line resets to tap 0
DELAY_LINE_MOVE  output  NUM_LANES  one-cycle move pulse, one tap per pulse
DELAY_LINE_DIRECTION  output  NUM_LANES  1 = increment; held 1 for the active lane while BUSY
TRAIN_BUSY  output  1  high from the cycle after an accepted START until DONE
TRAIN_DONE  output  1  level; high after the sweep completes, cleared by the next accepted START
TRAIN_FAIL  output  NUM_LANES  per-lane failure flag, valid when DONE
LANE_TAP  output  NUM_LANES*TAP_BITS  lane i occupies bits [i*TAP_BITS +: TAP_BITS]; edge tap, 0 if the lane failed

Behaviour:
- Reset (synchronous, RESET high at an edge):
  - state IDLE, lane index 0
  - all outputs 0, including LANE_TAP, TRAIN_FAIL and TRAIN_DONE
  - internal tap counter, sample counter and seen_zero cleared
  - a reset mid-sweep aborts immediately; no further LOAD/MOVE pulses are issued.
- FSM states: IDLE, LOAD, SETTLE, SAMPLE, DECIDE, MOVE, DONE.
- IDLE: TRAIN_START=1 sets the lane to 0 and clears TRAIN_DONE, TRAIN_FAIL and LANE_TAP. Next state is LOAD.
- LOAD: DELAY_LINE_LOAD[lane]=1 for exactly 1 cycle. The tap counter and seen_zero are set to 0. Next state is SETTLE.
- SETTLE: lasts exactly SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE: lasts exactly SAMPLE_COUNT cycles and ANDs RX_DATA_IN[lane] over the window. The result is 1 only if all samples were 1; a mixed window counts as 0.
- DECIDE (1 cycle), evaluated in priority order:
  1. result=0: set seen_zero.
  2. result=1 and seen_zero=1: edge found. LANE_TAP[lane] = tap counter; the lane is finished.
  3. Otherwise (no edge), if DELAY_LINE_OUT_OF_RANGE[lane]=1 or tap counter = MAX_TAP: TRAIN_FAIL[lane]=1, LANE_TAP[lane]=0, lane finished.
  4. Otherwise: go to MOVE.
- A result of 1 seen before any 0 (starting inside the high region) is not an edge; the sweep continues.
- MOVE: DELAY_LINE_MOVE[lane]=1 with DIRECTION[lane]=1 for exactly 1 cycle. Tap counter +1. Next state is SETTLE.
- Lane finished: if lane < NUM_LANES-1, increment the lane and go to LOAD directly in the next cycle. Otherwise go to DONE.
- DONE: TRAIN_BUSY=0, TRAIN_DONE=1. Next state is IDLE; TRAIN_DONE, TRAIN_FAIL and LANE_TAP stay held.
- Only the active lane's LOAD, MOVE and DIRECTION bits may ever be 1.
- TRAIN_START while BUSY is ignored.
- Per-tap timing:
  - tap 0 costs 1 + SETTLE_CYCLES + SAMPLE_COUNT + 1 cycles
  - every further tap costs the same (its MOVE cycle replaces the LOAD cycle).
- The tap counter is TAP_BITS wide and never wraps, because MAX_TAP bounds it.

Test Plan:
- NUM_LANES=2, defaults. Lane0 RX=0 for taps 0-2 and 1 from tap 3; lane1 edge at tap 10. -> Lane0: MOVE[0] pulses 3 times. LANE_TAP=(10<<8)|3, TRAIN_FAIL=0, DONE=1. Lane0 sweep = 40 cycles from LOAD[0] through its DECIDE.
- Lane0 RX=1 for taps 0-4, 0 for taps 5-8, 1 from tap 9. -> LANE_TAP[7:0]=9 (initial high region skipped), FAIL[0]=0.
- Lane1 RX stuck 0. -> 127 MOVE pulses on lane1, then FAIL[1]=1, LANE_TAP[15:8]=0, DONE=1.
- Lane0 OUT_OF_RANGE asserted at tap 20 with no edge. -> FAIL[0]=1 at that DECIDE. Lane1 then starts with LOAD[1] the next cycle.
- Lane0 SAMPLE window at tap 3 of 1,1,0,1, then all-1 at tap 4. -> tap 3 treated as 0, LANE_TAP[7:0]=4.
- RESET high for one cycle mid-SETTLE on lane1. -> next cycle all outputs 0 and IDLE. A second TRAIN_START while BUSY is ignored; a START after reset re-trains from lane0 tap 0.
